// File: rtl/lcd_edit_pkg.sv
// lcd_edit_pkg: keycodes, states and fill character shared by the LCD edit controller and its bench
package lcd_edit_pkg;
   localparam logic [7:0] KC_ESC   = 8'h76;
   localparam logic [7:0] KC_ENTER = 8'h5A;
   localparam logic [7:0] KC_BKSP  = 8'h66;
   localparam logic [7:0] KC_LEFT  = 8'h6B;
   localparam logic [7:0] KC_RIGHT = 8'h74;
   localparam logic [7:0] BLANK    = 8'h20;
   typedef enum logic {IDLE, CLEAR} state_e;
endpackage

// File: rtl/lcd_edit_controller.sv
// lcd_edit_controller: cursor-based editor turning PS/2 key events into LCD text RAM writes
module lcd_edit_controller
   import lcd_edit_pkg::*;
#(
   parameter int DEPTH    = 32,
   parameter int LINE_LEN = 16,
   parameter int AW       = 5
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          keycode_ready,
   input  logic          make,
   input  logic          ext,
   input  logic [7:0]    keycode,
   input  logic [7:0]    ascii,
   output logic [AW-1:0] waddr,
   output logic [7:0]    wdata,
   output logic          we,
   output logic [AW-1:0] cursor,
   output logic          busy
);
   state_e        state_q, state_d;
   logic [AW-1:0] sweep_q, sweep_d, cursor_q, cursor_d, waddr_q, waddr_d;
   logic [7:0]    wdata_q, wdata_d;
   logic          we_q, we_d;
   logic          accept, last_clear, printable;
   assign accept     = keycode_ready & make & (state_q == IDLE);
   // the final sweep write is on the outputs this cycle, so the sweep ends here
   assign last_clear = (state_q == CLEAR) & we_q & (waddr_q == AW'(DEPTH - 1));
   assign printable  = (ascii >= 8'h20) & (ascii <= 8'h7E);
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= CLEAR;
         sweep_q  <= '0;
         cursor_q <= '0;
         waddr_q  <= '0;
         wdata_q  <= BLANK;
         we_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         sweep_q  <= sweep_d;
         cursor_q <= cursor_d;
         waddr_q  <= waddr_d;
         wdata_q  <= wdata_d;
         we_q     <= we_d;
      end
   end
   always_comb
      state_d = (state_q == CLEAR) ? (last_clear ? IDLE : CLEAR)
                                   : ((accept && keycode == KC_ESC) ? CLEAR : IDLE);
   always_comb begin
      sweep_d  = sweep_q;
      cursor_d = cursor_q;
      waddr_d  = waddr_q;
      wdata_d  = wdata_q;
      we_d     = 1'b0;
      if (state_q == CLEAR) begin
         if (last_clear) begin
            cursor_d = '0;
         end else begin
            we_d    = 1'b1;
            waddr_d = sweep_q;
            wdata_d = BLANK;
            sweep_d = sweep_q + AW'(1);
         end
      end else if (accept) begin
         // Esc writes cell 0 immediately so the sweep occupies exactly DEPTH busy cycles
         if (keycode == KC_ESC) begin
            we_d    = 1'b1;
            waddr_d = '0;
            wdata_d = BLANK;
            sweep_d = AW'(1);
         end else if (ext && keycode == KC_LEFT) begin
            cursor_d = cursor_q - AW'(1);
         end else if (ext && keycode == KC_RIGHT) begin
            cursor_d = cursor_q + AW'(1);
         end else if (keycode == KC_ENTER) begin
            cursor_d = (cursor_q < AW'(LINE_LEN)) ? AW'(LINE_LEN) : '0;
         end else if (keycode == KC_BKSP) begin
            if (cursor_q != '0) begin
               cursor_d = cursor_q - AW'(1);
               we_d     = 1'b1;
               waddr_d  = cursor_q - AW'(1);
               wdata_d  = BLANK;
            end
         end else if (!ext && printable) begin
            we_d     = 1'b1;
            waddr_d  = cursor_q;
            wdata_d  = ascii;
            cursor_d = cursor_q + AW'(1);
         end
      end
   end
   assign waddr  = waddr_q;
   assign wdata  = wdata_q;
   assign we     = we_q;
   assign cursor = cursor_q;
   assign busy   = (state_q == CLEAR);
endmodule

// File: tb/tb_lcd_edit_controller.sv
// tb_lcd_edit_controller: scoreboard bench; stimulus queues expected writes, a monitor checks each we pulse
module tb_lcd_edit_controller;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       keycode_ready = 1'b0;
   logic       make = 1'b0;
   logic       ext = 1'b0;
   logic [7:0] keycode = 8'h00;
   logic [7:0] ascii = 8'h00;
   logic [4:0] waddr;
   logic [7:0] wdata;
   logic       we;
   logic [4:0] cursor;
   logic       busy;
   int         total = 0;
   int         bad = 0;
   logic [12:0] exp_q[$];

   lcd_edit_controller dut (
      .clk(clk), .reset(reset), .keycode_ready(keycode_ready), .make(make), .ext(ext),
      .keycode(keycode), .ascii(ascii), .waddr(waddr), .wdata(wdata), .we(we),
      .cursor(cursor), .busy(busy)
   );

   always #10 clk = ~clk;

   always @(negedge clk) begin
      if (we) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_write got addr=%0d data=%0h, none expected", waddr, wdata);
         end else begin
            logic [12:0] e;
            e = exp_q.pop_front();
            if ({waddr, wdata} !== e) begin
               bad++;
               $display("FAIL write got addr=%0d data=%0h, expected addr=%0d data=%0h",
                        waddr, wdata, e[12:8], e[7:0]);
            end
         end
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic push_sweep();
      for (int i = 0; i < 32; i++) exp_q.push_back({i[4:0], 8'h20});
   endtask

   task automatic send(input logic [7:0] kc, input logic e, input logic m, input logic [7:0] a);
      @(negedge clk);
      keycode = kc; ext = e; make = m; ascii = a; keycode_ready = 1'b1;
      @(negedge clk);
      keycode_ready = 1'b0;
   endtask

   task automatic wait_idle(input int lim);
      int n = 0;
      while (busy && n < lim) begin
         @(negedge clk);
         n++;
      end
      if (busy) begin
         total++;
         bad++;
         $display("FAIL wait_idle got busy=1 after %0d cycles, expected 0", lim);
      end
   endtask

   initial begin
      int cnt;
      push_sweep();
      repeat (3) @(negedge clk);
      chk("rst_we", we, 0);
      chk("rst_waddr", waddr, 0);
      chk("rst_wdata", wdata, 8'h20);
      chk("rst_cursor", cursor, 0);
      chk("rst_busy", busy, 1);
      reset = 1'b0;
      wait_idle(100);
      chk("init_sweep_drained", exp_q.size(), 0);
      chk("init_cursor", cursor, 0);
      exp_q.push_back({5'd0, 8'h41});
      send(8'h1C, 1'b0, 1'b1, 8'h41);
      chk("type_A_we", we, 1);
      chk("type_A_cursor", cursor, 1);
      send(8'h1C, 1'b0, 1'b0, 8'h41);
      chk("break_cursor", cursor, 1);
      send(8'h6B, 1'b1, 1'b1, 8'h00);
      chk("left_1_0", cursor, 0);
      send(8'h6B, 1'b1, 1'b1, 8'h00);
      chk("left_wrap", cursor, 31);
      exp_q.push_back({5'd31, 8'h42});
      send(8'h32, 1'b0, 1'b1, 8'h42);
      chk("type_B_wrap", cursor, 0);
      send(8'h5A, 1'b0, 1'b1, 8'h00);
      chk("enter_to_16", cursor, 16);
      send(8'h5A, 1'b1, 1'b1, 8'h00);
      chk("enter_to_0", cursor, 0);
      send(8'h1C, 1'b1, 1'b1, 8'h41);
      chk("ext_printable_ignored", cursor, 0);
      repeat (5) send(8'h74, 1'b1, 1'b1, 8'h00);
      chk("right_x5", cursor, 5);
      exp_q.push_back({5'd4, 8'h20});
      send(8'h66, 1'b0, 1'b1, 8'h00);
      chk("bksp_cursor", cursor, 4);
      chk("bksp_we", we, 1);
      repeat (4) send(8'h6B, 1'b1, 1'b1, 8'h00);
      chk("left_x4", cursor, 0);
      send(8'h66, 1'b0, 1'b1, 8'h00);
      chk("bksp_at_0_cursor", cursor, 0);
      chk("bksp_at_0_we", we, 0);
      send(8'h6B, 1'b1, 1'b1, 8'h00);
      chk("left_at_0", cursor, 31);
      chk("left_at_0_we", we, 0);
      repeat (10) send(8'h74, 1'b1, 1'b1, 8'h00);
      chk("right_x10_wrap", cursor, 9);
      push_sweep();
      send(8'h76, 1'b0, 1'b1, 8'h00);
      cnt = 0;
      while (busy && cnt < 100) begin
         if (cnt == 10) begin
            keycode = 8'h21; ext = 1'b0; make = 1'b1; ascii = 8'h43; keycode_ready = 1'b1;
         end else begin
            keycode_ready = 1'b0;
         end
         cnt++;
         @(negedge clk);
      end
      keycode_ready = 1'b0;
      chk("esc_busy_cycles", cnt, 32);
      chk("esc_cursor", cursor, 0);
      chk("esc_sweep_drained", exp_q.size(), 0);
      push_sweep();
      send(8'h76, 1'b0, 1'b1, 8'h00);
      cnt = 0;
      while (!(we && waddr == 5'd12) && cnt < 100) begin
         @(negedge clk);
         cnt++;
      end
      chk("reached_addr12", int'(we && waddr == 5'd12), 1);
      #1;
      exp_q.delete();
      reset = 1'b1;
      @(negedge clk);
      chk("midrst_we", we, 0);
      chk("midrst_busy", busy, 1);
      chk("midrst_waddr", waddr, 0);
      push_sweep();
      reset = 1'b0;
      wait_idle(100);
      chk("restart_drained", exp_q.size(), 0);
      chk("restart_cursor", cursor, 0);
      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
